// File: rtl/fetch_unit.sv
// LC-3b instruction fetch stage: owns the PC, handshakes with instruction memory,
// and writes pc/ir into IF/ID, with a one-entry hold buffer and redirect handling.
//
// state  | meaning
// -------+------------------------------------------------------------------
// S_REQ  | read outstanding at pc; deliver or discard on imem_resp
// S_HOLD | response captured while stalled; waiting to hand it to IF/ID
module fetch_unit (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic [15:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_id_load,
    output logic [15:0] pc_out,
    output logic [15:0] ir_out
);

    localparam logic [0:0] S_REQ  = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]  state;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [15:0] hold_ir;
    logic [15:0] hold_pc;
    logic [15:0] redir_tgt;
    logic        redir_pend;
    logic        resp_good;

    assign pc_inc = pc + 16'd2;

    // A response is only usable if no redirect is pending or arriving with it.
    assign resp_good = (state == S_REQ) && imem_resp && !redir_pend && !redirect;

    always_comb begin
        imem_read    = 1'b0;
        imem_address = pc;
        if_id_load   = 1'b0;
        ir_out       = 16'h0000;
        pc_out       = 16'h0000;
        if (reset_n) begin
            if_id_load = ~stall;
            pc_out     = pc;
            case (state)
                S_REQ: begin
                    imem_read = 1'b1;
                    if (resp_good) begin
                        ir_out = imem_rdata;
                        pc_out = pc_inc;
                    end
                end
                S_HOLD: begin
                    if (!redirect) begin
                        ir_out = hold_ir;
                        pc_out = hold_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_REQ;
            pc         <= 16'h0000;
            hold_ir    <= 16'h0000;
            hold_pc    <= 16'h0000;
            redir_pend <= 1'b0;
            redir_tgt  <= 16'h0000;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_resp) begin
                        if (redir_pend || redirect) begin
                            pc         <= redirect ? redirect_pc : redir_tgt;
                            redir_pend <= 1'b0;
                        end else begin
                            pc <= pc_inc;
                            if (stall) begin
                                hold_ir <= imem_rdata;
                                hold_pc <= pc_inc;
                                state   <= S_HOLD;
                            end
                        end
                    end else if (redirect) begin
                        // The request cannot be aborted; remember where to go once it completes.
                        redir_pend <= 1'b1;
                        redir_tgt  <= redirect_pc;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc      <= redirect_pc;
                        hold_ir <= 16'h0000;
                        hold_pc <= 16'h0000;
                        state   <= S_REQ;
                    end else if (!stall) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed test of fetch_unit: inputs change on the falling edge, outputs are
// checked 1 ns later, well away from the rising edge.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_id_load;
    logic [15:0] pc_out;
    logic [15:0] ir_out;

    int n_total = 0;
    int n_pass  = 0;

    fetch_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_id_load   (if_id_load),
        .pc_out       (pc_out),
        .ir_out       (ir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Advance to the next falling edge, then apply the next cycle's inputs.
    task automatic drive(input logic rst, input logic rsp, input logic [15:0] rd,
                         input logic stl, input logic rdr, input logic [15:0] rpc);
        @(negedge clk);
        reset_n     = rst;
        imem_resp   = rsp;
        imem_rdata  = rd;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        reset_n = 1'b0; imem_resp = 1'b0; imem_rdata = '0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset outputs (resp/rdata driven to show gating)
        drive(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000);
        chk1 ("rst_read", imem_read, 1'b0);
        chk1 ("rst_load", if_id_load, 1'b0);
        chk16("rst_pc",   pc_out, 16'h0000);
        chk16("rst_ir",   ir_out, 16'h0000);

        // Zero-wait memory
        drive(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000);
        chk1 ("zw0_read", imem_read, 1'b1);
        chk16("zw0_addr", imem_address, 16'h0000);
        chk1 ("zw0_load", if_id_load, 1'b1);
        chk16("zw0_ir",   ir_out, 16'h1234);
        chk16("zw0_pc",   pc_out, 16'h0002);
        drive(1'b1, 1'b1, 16'h5678, 1'b0, 1'b0, 16'h0000);
        chk16("zw1_addr", imem_address, 16'h0002);
        chk1 ("zw1_load", if_id_load, 1'b1);
        chk16("zw1_ir",   ir_out, 16'h5678);
        chk16("zw1_pc",   pc_out, 16'h0004);

        // 3-cycle latency
        do_reset();
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk16("lat0_addr", imem_address, 16'h0000);
        chk16("lat0_ir",   ir_out, 16'h0000);
        chk1 ("lat0_load", if_id_load, 1'b1);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk16("lat1_addr", imem_address, 16'h0000);
        chk16("lat1_ir",   ir_out, 16'h0000);
        drive(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000);
        chk16("lat2_addr", imem_address, 16'h0000);
        chk16("lat2_ir",   ir_out, 16'h1234);
        chk16("lat2_pc",   pc_out, 16'h0002);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk16("lat3_addr", imem_address, 16'h0002);

        // Stall across a response, then release
        do_reset();
        drive(1'b1, 1'b1, 16'h2222, 1'b1, 1'b0, 16'h0000);
        chk1 ("st0_load", if_id_load, 1'b0);
        chk1 ("st0_read", imem_read, 1'b1);
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
            chk1 ("st_hold_read", imem_read, 1'b0);
        end
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk1 ("st_rel_load", if_id_load, 1'b1);
        chk16("st_rel_ir",   ir_out, 16'h2222);
        chk16("st_rel_pc",   pc_out, 16'h0002);
        chk1 ("st_rel_read", imem_read, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk1 ("st_next_read", imem_read, 1'b1);
        chk16("st_next_addr", imem_address, 16'h0002);

        // Redirect during an outstanding request
        do_reset();
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h3000);
        chk16("rd0_addr", imem_address, 16'h0000);
        chk16("rd0_ir",   ir_out, 16'h0000);
        drive(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000);
        chk16("rd1_ir",   ir_out, 16'h0000);
        chk1 ("rd1_load", if_id_load, 1'b1);
        drive(1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0, 16'h0000);
        chk16("rd2_addr", imem_address, 16'h3000);
        chk16("rd2_ir",   ir_out, 16'hABCD);
        chk16("rd2_pc",   pc_out, 16'h3002);

        // Redirect while holding under stall
        do_reset();
        drive(1'b1, 1'b1, 16'h2222, 1'b1, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h4000);
        chk1 ("hr0_read", imem_read, 1'b0);
        chk1 ("hr0_load", if_id_load, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk1 ("hr1_read", imem_read, 1'b1);
        chk16("hr1_addr", imem_address, 16'h4000);
        chk16("hr1_ir",   ir_out, 16'h0000);

        // Two redirects during one request: latest wins
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h5000);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h6000);
        drive(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000);
        chk16("dr0_ir",   ir_out, 16'h0000);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk16("dr1_addr", imem_address, 16'h6000);

        // Redirect arriving with a response, to 0xFFFE, then wrap
        drive(1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 16'hFFFE);
        chk16("wr0_ir",   ir_out, 16'h0000);
        chk16("wr0_pc",   pc_out, 16'h6000);
        drive(1'b1, 1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000);
        chk16("wr1_addr", imem_address, 16'hFFFE);
        chk16("wr1_ir",   ir_out, 16'h7777);
        chk16("wr1_pc",   pc_out, 16'h0000);
        drive(1'b1, 1'b1, 16'h8888, 1'b0, 1'b0, 16'h0000);
        chk16("wr2_addr", imem_address, 16'h0000);
        chk16("wr2_pc",   pc_out, 16'h0002);

        // Reset in the middle of a request to 0x0002
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk16("mr0_addr", imem_address, 16'h0002);
        drive(1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 16'h0000);
        chk1 ("mr1_read", imem_read, 1'b0);
        chk1 ("mr1_load", if_id_load, 1'b0);
        chk16("mr1_ir",   ir_out, 16'h0000);
        chk16("mr1_pc",   pc_out, 16'h0000);
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk1 ("mr2_read", imem_read, 1'b1);
        chk16("mr2_addr", imem_address, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the LC-3b pipeline: owns the PC, runs the read handshake with instruction memory, and produces the `pc`/`ir` pair and load strobe written into the IF/ID pipeline register. It is the writer side of IF/ID. It absorbs downstream stalls with a one-entry hold buffer and handles control-flow redirects from later stages, inserting NOP bubbles whenever no valid instruction is available.

## Interface
- No parameters. Word width is fixed at 16 bits (`lc3b_word`).
- `clk` in 1 — sole clock; all state changes on its rising edge.
- `reset_n` in 1 — synchronous, active-low reset.
- `imem_read` out 1 — instruction-memory read request.
- `imem_address` out 16 — read address; equals the current PC while `imem_read`=1.
- `imem_rdata` in 16 — read data; valid only when `imem_resp`=1.
- `imem_resp` in 1 — one-cycle read completion.
- `stall` in 1 — IF/ID must not advance this cycle.
- `redirect` in 1 — taken branch/jump/trap from a later stage; one-cycle pulse.
- `redirect_pc` in 16 — target address, valid when `redirect`=1.
- `if_id_load` out 1 — load strobe for IF/ID.
- `pc_out` out 16 — incremented PC (fetch address + 2) of the delivered instruction.
- `ir_out` out 16 — delivered instruction, or 0x0000 (NOP, BR with nzp=000) for a bubble.

## Operation
- State: `pc` (16b), FSM {REQ, HOLD}, hold buffer `hold_ir`/`hold_pc`, `redir_pend` flag, `redir_tgt` (16b).
- Reset (`reset_n`=0 at an edge): `pc`=0x0000, state=REQ, `redir_pend`=0, hold buffer cleared. Outputs while `reset_n`=0: `imem_read`=0, `if_id_load`=0, `pc_out`=0x0000, `ir_out`=0x0000.
- The `if_id_load` output equals `~stall` whenever `reset_n`=1. IF/ID therefore always advances when not stalled, receiving either a real instruction or a NOP.
- REQ state:
  - `imem_read`=1 and `imem_address`=`pc`. Address and read stay stable until `imem_resp`; a request is never aborted.
  - `imem_resp`=1, `redir_pend`=0, no `redirect`, `stall`=0: `ir_out`=`imem_rdata`, `pc_out`=`pc`+2, `pc`<=`pc`+2, remain in REQ.
  - `imem_resp`=1, `redir_pend`=0, no `redirect`, `stall`=1: `hold_ir`<=`imem_rdata`, `hold_pc`<=`pc`+2, `pc`<=`pc`+2, go to HOLD.
  - `imem_resp`=1 and (`redir_pend`=1 or `redirect`=1): discard the data. `pc`<=(`redirect` ? `redirect_pc` : `redir_tgt`), clear `redir_pend`, remain in REQ. Bubble output.
  - `imem_resp`=0 with `redirect`=1: `redir_pend`<=1 and `redir_tgt`<=`redirect_pc`. A later redirect overwrites the target (latest wins).
  - No deliverable instruction: `ir_out`=0x0000, `pc_out`=`pc`.
- HOLD state:
  - `imem_read`=0.
  - `stall`=0 and no `redirect`: `ir_out`=`hold_ir`, `pc_out`=`hold_pc`, go to REQ.
  - `stall`=1: outputs are don't-care (not loaded), remain in HOLD.
  - `redirect`=1 (regardless of `stall`): drop the buffer, `pc`<=`redirect_pc`, go to REQ. Output a bubble if `stall`=0.
- `redirect` always takes priority over `stall` and over delivering a buffered or arriving instruction.
- PC arithmetic is 16-bit modulo: 0xFFFE+2 wraps to 0x0000. Bit 0 of `redirect_pc` is passed through unchanged (alignment is the producer's responsibility).

## Timing
- `ir_out`, `pc_out`, `if_id_load`, `imem_read`, and `imem_address` are combinational from state and inputs. An instruction arriving with `imem_resp` is written into IF/ID at that same edge: fetch-to-IF/ID latency is 0 cycles after the response.
- The next request issues the cycle after an accepted response. With zero-wait memory (`imem_resp` in the first cycle of `imem_read`), throughput is 1 instruction/cycle.
- HOLD→REQ: the buffered instruction loads at the release edge, and the new request starts the following cycle.
- A redirect issued during an outstanding request costs that request's remaining latency plus one fetch. The first target instruction is delivered no earlier than the cycle after the discarded response.
- Reset mid-request: the request is dropped immediately (`imem_read`=0 during reset). The first post-reset request is to 0x0000 in the first cycle with `reset_n`=1.

## Test plan
- Reset then zero-wait memory returning 0x1234, 0x5678: `imem_address` 0x0000, 0x0002 on consecutive cycles. IF/ID receives (pc 0x0002, ir 0x1234) then (0x0004, 0x5678), with `if_id_load`=1 on both cycles.
- 3-cycle memory latency: `imem_address` held at 0x0000 for all 3 cycles. `ir_out`=0x0000 bubbles with `if_id_load`=1 until `resp`, then ir 0x1234 with pc 0x0002.
- `stall`=1 for 4 cycles spanning a response carrying 0x2222: `imem_read`=0 during HOLD. On release, IF/ID gets (0x0002, 0x2222), and the next request goes to 0x0002.
- `redirect`=1, `redirect_pc`=0x3000 two cycles into a 3-cycle request at 0x0000: the data returned for 0x0000 is dropped with ir 0x0000 loaded. The next `imem_address` is 0x3000, and the delivered pc is 0x3002.
- `redirect` in HOLD with `stall`=1 (target 0x4000): the hold buffer is discarded and the next fetch goes to 0x4000. Two redirects (0x5000, then 0x6000) during one request: the fetch goes to 0x6000.
- `pc` forced to 0xFFFE via redirect: `pc_out`=0x0000 and the next fetch is from 0x0000. Assert `reset_n`=0 mid-request: `imem_read`=0 in that cycle, then a fetch from 0x0000.
